// File: rtl/lc3_mem_arbiter_if.sv
// rtl/lc3_mem_arbiter_if.sv - request, response and RAM-port signals of the LC-3 memory arbiter
interface lc3_mem_arbiter_if #(parameter int WIDTH = 16);
  logic             ifReq;
  logic [WIDTH-1:0] ifAddr;
  logic [WIDTH-1:0] ifData;
  logic             ifValid;
  logic             memReq;
  logic             memWe;
  logic             memInd;
  logic [WIDTH-1:0] memAddr;
  logic [WIDTH-1:0] memWdata;
  logic [WIDTH-1:0] memRdata;
  logic             memDone;
  logic             pause;
  logic             ramEn;
  logic             ramWe;
  logic [WIDTH-1:0] ramAddr;
  logic [WIDTH-1:0] ramWdata;
  logic [WIDTH-1:0] ramRdata;

  modport slave (
    input  ifReq, ifAddr, memReq, memWe, memInd, memAddr, memWdata, ramRdata,
    output ifData, ifValid, memRdata, memDone, pause, ramEn, ramWe, ramAddr, ramWdata
  );

  modport master (
    output ifReq, ifAddr, memReq, memWe, memInd, memAddr, memWdata, ramRdata,
    input  ifData, ifValid, memRdata, memDone, pause, ramEn, ramWe, ramAddr, ramWdata
  );
endinterface

// File: rtl/lc3_mem_arbiter.sv
// rtl/lc3_mem_arbiter.sv - single-port RAM arbiter between IF and MEM with LDI/STI sequencing
module lc3_mem_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  lc3_mem_arbiter_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, IF_RD, M_RD, IND_PTR, IND_ISSUE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] ptr;
  logic             if_held;
  logic [WIDTH-1:0] if_hold;
  logic             mem_held;
  logic [WIDTH-1:0] mem_hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      if_held  <= 1'b0;
      if_hold  <= '0;
      mem_held <= 1'b0;
      mem_hold <= '0;
    end else begin
      state <= state_next;
      if (state == IND_PTR)
        ptr <= bus.ramRdata;
      // Held results only survive while the pipeline is still frozen.
      if (!bus.pause) begin
        if_held  <= 1'b0;
        mem_held <= 1'b0;
      end else begin
        if (bus.memDone) begin
          mem_held <= 1'b1;
          mem_hold <= bus.memRdata;
        end
        if (bus.ifValid) begin
          if_held <= 1'b1;
          if_hold <= bus.ifData;
        end
      end
    end
  end

  always_comb begin
    state_next   = state;
    bus.ramEn    = 1'b0;
    bus.ramWe    = 1'b0;
    bus.ramAddr  = '0;
    bus.ramWdata = '0;
    bus.ifValid  = 1'b0;
    bus.ifData   = '0;
    bus.memDone  = 1'b0;
    bus.memRdata = '0;
    bus.pause    = 1'b0;

    if (!reset) begin
      if (if_held) begin
        bus.ifValid = 1'b1;
        bus.ifData  = if_hold;
      end
      if (mem_held) begin
        bus.memDone  = 1'b1;
        bus.memRdata = mem_hold;
      end

      case (state)
        IDLE: begin
          // MEM is the older instruction, so it wins the port.
          if (bus.memReq && !mem_held) begin
            bus.ramEn   = 1'b1;
            bus.ramAddr = bus.memAddr;
            if (bus.memInd) begin
              state_next = IND_PTR;
            end else if (bus.memWe) begin
              bus.ramWe    = 1'b1;
              bus.ramWdata = bus.memWdata;
              bus.memDone  = 1'b1;
            end else begin
              state_next = M_RD;
            end
          end else if (bus.ifReq && !if_held) begin
            bus.ramEn   = 1'b1;
            bus.ramAddr = bus.ifAddr;
            state_next  = IF_RD;
          end
        end
        IF_RD: begin
          bus.ifValid = 1'b1;
          bus.ifData  = bus.ramRdata;
          state_next  = IDLE;
        end
        M_RD: begin
          bus.memDone  = 1'b1;
          bus.memRdata = bus.ramRdata;
          state_next   = IDLE;
        end
        IND_PTR: begin
          state_next = IND_ISSUE;
        end
        IND_ISSUE: begin
          bus.ramEn   = 1'b1;
          bus.ramAddr = ptr;
          if (bus.memWe) begin
            bus.ramWe    = 1'b1;
            bus.ramWdata = bus.memWdata;
            bus.memDone  = 1'b1;
            state_next   = IDLE;
          end else begin
            state_next = M_RD;
          end
        end
        default: state_next = IDLE;
      endcase

      bus.pause = (bus.memReq && !bus.memDone) || (bus.ifReq && !bus.ifValid);
    end
  end

endmodule

// File: doc/lc3_mem_arbiter.md
# lc3_mem_arbiter

Single-port memory arbiter and access sequencer for the LC-3 pipeline. Shares one synchronous RAM between instruction fetch (IF) and the MEM stage, and sequences the two-access indirect operations (LDI, STI) whose first address comes from the EX stage's `exALUoutput`. It drives the pipeline-wide `pause` so every stage, including EX, freezes until both requesters are served.

## Interface
- `WIDTH`, default 16: address and data width. Only 16 is supported.

- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `ifReq` in 1: fetch request.
- `ifAddr` in WIDTH: fetch address (PC).
- `ifData` out WIDTH: fetched instruction.
- `ifValid` out 1: `ifData` is valid.
- `memReq` in 1: MEM-stage request.
- `memWe` in 1: 1 = store (ST/STR/STI), 0 = load.
- `memInd` in 1: indirect access (LDI/STI).
- `memAddr` in WIDTH: effective address (`exALUoutput`).
- `memWdata` in WIDTH: store data (`exTMP`).
- `memRdata` out WIDTH: load result.
- `memDone` out 1: MEM access complete.
- `pause` out 1: freeze the whole pipeline.
- `ramEn` out 1: RAM access strobe.
- `ramWe` out 1: RAM write strobe.
- `ramAddr` out WIDTH: RAM address.
- `ramWdata` out WIDTH: RAM write data.
- `ramRdata` in WIDTH: RAM read data, valid the cycle after a read issues.

## Operation
- **RAM port.** At most one RAM access per cycle. The `ram*` outputs are combinational from the FSM state and the inputs. Whenever `ramEn` = 0, `ramWe`, `ramAddr` and `ramWdata` are 0.
- **FSM states.** IDLE, IF_RD, M_RD, IND_PTR, IND_ISSUE. A pointer register `ptr` (WIDTH bits) holds the indirect pointer.
- **Held flags.**
  - `ifHeld`/`ifHold` and `memHeld`/`memHold` record a completed access and its data while `pause` remains high.
  - All held flags clear on any cycle with `pause` = 0.
  - A held requester is never re-issued.
- **Priority.** MEM has priority over IF because it is the older instruction. IF issues only when `memReq` = 0 or `memHeld` = 1.
- **IDLE, MEM pending and not held.**
  - Direct write: issue the write with `ramWe` = 1; `memDone` = 1 in the same cycle; stay in IDLE.
  - Direct read: issue the read; go to M_RD.
  - Indirect access: issue a read of `memAddr`; go to IND_PTR.
- **IDLE, IF selected.** Issue a read of `ifAddr`; go to IF_RD.
- **IF_RD.** `ifValid` = 1 and `ifData` = `ramRdata`; capture into `ifHold`; go to IDLE. The port is idle in this state.
- **M_RD.** `memDone` = 1 and `memRdata` = `ramRdata`; capture into `memHold`; go to IDLE.
- **IND_PTR.** Latch `ptr` ← `ramRdata`; go to IND_ISSUE. The port is idle.
- **IND_ISSUE.**
  - STI (`memWe` = 1): write `memWdata` to `ptr`; `memDone` = 1 this cycle; go to IDLE.
  - LDI: read `ptr`; go to M_RD.
- **Held outputs.** While a held flag is set, the output comes from the hold register: `ifValid` = 1 with `ifData` = `ifHold`, and `memDone` = 1 with `memRdata` = `memHold`.
- **Inactive outputs.** When not valid or done, `ifData` and `memRdata` are 0.
- **Pause.** `pause` = (`memReq` & !`memDone`) | (`ifReq` & !`ifValid`), and is forced to 0 while `reset` = 1.
- **Request stability.** Requesters hold their request inputs stable while `pause` = 1. Behaviour under a violation is undefined.
- **Reset.** Applies to the next clock edge:
  - state → IDLE, all held flags → 0, `ptr` and hold registers → 0;
  - in the reset cycle all `ram*` outputs are 0;
  - `ifValid`, `memDone`, `ifData`, `memRdata` and `pause` are 0.
  - A reset mid-indirect abandons the access; an in-flight RAM read result is discarded.

## Timing
- Cycle T is the first cycle a request is serviceable.
- IF fetch: issue at T, `ifValid` at T+1. At most one fetch per 2 cycles.
- Direct load: issue at T, `memDone` at T+1.
- Direct store: issue and `memDone` both at T.
- LDI: pointer read at T, `ptr` latched at T+1, data read at T+2, `memDone` at T+3.
- STI: pointer read at T, write at T+2, `memDone` at T+2.
- MEM and IF pending together: MEM is served first; IF issues on the first IDLE cycle after `memDone` (with `memHeld` then set), so `pause` drops 2 cycles later.
- Only `memReq` active: `pause` drops in the `memDone` cycle.
- Held flags set on the clock edge that ends a done/valid cycle, and only if `pause` was 1 in that cycle.

## Test plan
1. **Reset.**
   - Stimulus: RAM preloaded with [0x3000] = 0x1234; hold `reset` = 1 with `ifReq` = 1, `ifAddr` = 0x3000.
   - Required: `ramEn` = 0 and `pause` = 0 for the whole reset period.
   - After release: `ramEn`/`ramAddr` = 1/0x3000 in the first cycle, then `ifValid` = 1 with `ifData` = 0x1234, `pause` = 0.
2. **Contention.**
   - Stimulus: `memReq` = 1 (load of 0x4000 = 0xBEEF) and `ifReq` = 1 (0x3001 = 0x5020) both pending at T.
   - Required: RAM address 0x4000 at T; `memDone` = 1 with `memRdata` = 0xBEEF at T+1; 0x3001 read at T+2; `ifValid` = 1 at T+3; `pause` = 1 through T+2 and 0 at T+3.
   - Required: `memDone` stays 1 with 0xBEEF through T+3, and there is no second read of 0x4000.
3. **LDI.**
   - Stimulus: [0x4000] = 0x5000, [0x5000] = 0x00AA; LDI with `memAddr` = 0x4000 at T.
   - Required: `ramAddr` is 0x4000 at T, idle at T+1, 0x5000 at T+2; `memDone` = 1 with `memRdata` = 0x00AA at T+3.
4. **STI.**
   - Stimulus: [0x4000] = 0x5000; STI with `memWdata` = 0x7777 at T.
   - Required: write `ramWe` = 1 to 0x5000 with 0x7777 at T+2; `memDone` at T+2; afterwards [0x5000] = 0x7777.
5. **Direct store alone.**
   - Stimulus: ST with `memAddr` = 0x4100, `memWdata` = 0x0001, `ifReq` = 0.
   - Required: write at T with `memDone` = 1 and `pause` = 0 at T; no further RAM access.
6. **Reset mid-indirect.**
   - Stimulus: assert `reset` at T+1 of an STI.
   - Required: no write to the pointer location ever occurs; state is IDLE and `memDone` = 0 after release; the STI re-issues from scratch if `memReq` is still 1.
